pic_exec_seq: RTL
=================

Name: pic_exec_seq

Overview:
- Four-phase (Q1..Q4) instruction-cycle sequencer for the iCEPIC core.
- Owns the program counter, the instruction register and the one-word prefetch.
- Drives the ALU opcode, register-file read/write strobes, the W write and the STATUS write.
- Converts ALU skip results and decoded branches into a one-cycle pipeline flush; the flushed cycle executes as NOP.
- Sits between program memory / decoder and the alu / register file.

Parameters:
- PC_W, 13, program counter width in bits.
- RESET_VECTOR, 0, PC value after reset.
- NOP_WORD, 14'h0000, instruction word injected on flush or fetch miss.

Ports:
- clk_in  input  1  core clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- instr_in  input  14  program memory read data for pc_out, sampled at Q4.
- instr_valid_in  input  1  instr_in valid at Q4.
- dec_alu_op_in  input  alu_op_t  ALU op decoded from instr_reg_out.
- dec_dest_f_in  input  1  d bit: 1 = result to file register, 0 = to W.
- dec_file_addr_in  input  7  file register address decoded from instr_reg_out.
- dec_branch_in  input  1  instruction loads the PC (GOTO/CALL class).
- dec_target_in  input  PC_W  branch target.
- alu_skip_in  input  1  ALU skip_flag.
- alu_status_update_in  input  1  ALU status_update.
- phase_out  output  2  current phase: 0 = Q1 .. 3 = Q4.
- instr_reg_out  output  14  instruction under execution.
- alu_op_out  output  alu_op_t  opcode presented to the ALU.
- file_rd_en_out  output  1  register file read strobe.
- file_addr_out  output  7  register file address.
- file_wr_en_out  output  1  register file write strobe.
- w_wr_en_out  output  1  W register write strobe.
- status_wr_en_out  output  1  STATUS write strobe.
- pc_out  output  PC_W  fetch address.
- flush_out  output  1  current instruction cycle is a flush NOP.

Behaviour:
- Reset (async, rst_n_in low):
  - phase = Q1, pc_out = RESET_VECTOR, instr_reg_out = NOP_WORD, flush_out = 1.
  - All strobes 0, alu_op_out = ALU_NOP, file_addr_out = 0.
  - Reset asserted mid-cycle aborts that cycle; no write strobe may pulse afterwards.
- Phase counter:
  - Advances every clock; Q4 wraps to Q1. One instruction cycle = 4 clocks.
- Per-phase actions (all suppressed while flush_out = 1, except fetch and PC):
  - Q1: file_addr_out <= dec_file_addr_in.
  - Q2: file_rd_en_out = 1 for one clock.
  - Q3:
    - alu_op_out = dec_alu_op_in during Q3 and Q4; ALU_NOP during Q1/Q2 and whole flush cycles.
    - At the end of Q3, register skip_pending <= alu_skip_in.
  - Q4, writeback, one-clock pulses:
    - file_wr_en_out = dec_dest_f_in.
    - w_wr_en_out = !dec_dest_f_in.
    - Neither is asserted for ALU_NOP, ALU_BIT_BTFSS or ALU_BIT_BTFSC.
    - status_wr_en_out = alu_status_update_in.
- Fetch at the Q4 clock edge:
  - instr_valid_in = 1: instr_reg_out <= instr_in; pc_out <= pc_out + 1, wrapping modulo 2^PC_W.
  - instr_valid_in = 0: instr_reg_out <= NOP_WORD, pc_out holds, next cycle not flagged as flush (fetch retry).
  - dec_branch_in = 1 (not in flush): pc_out <= dec_target_in, instr_reg_out <= NOP_WORD, next flush_out = 1.
  - skip_pending = 1 (not in flush): pc increments normally, instr_reg_out <= NOP_WORD, next flush_out = 1.
  - Skip and branch together: branch wins, single flush cycle.
- Flush:
  - flush_out updates only at the Q4 edge.
  - A flush cycle cannot itself generate a flush; its skip/branch inputs are ignored.
  - Consecutive skip instructions each cost exactly one flush cycle.

Optional Feature:
- Macro: ICEPIC_EXEC_STALL_EN.
- Enabled:
  - Adds port stall_in (input, 1).
  - While stall_in = 1, the phase counter, PC, instr_reg and skip_pending hold, and all strobes are forced 0.
  - On release, the held phase resumes; its strobe fires once.
  - Stall has no effect on reset.
- Disabled: no port; phase advances unconditionally.

Test Plan:
- Reset release with instr_valid_in = 1 and instr_in = 14'h0A05: first cycle has flush_out = 1 and no strobes; instr_reg_out = 14'h0A05 after the first Q4; pc_out = 1.
- Op ALU_ADD, dec_dest_f_in = 1, addr 7'h0C, alu_status_update_in = 1: file_rd_en_out pulses at Q2; file_wr_en_out and status_wr_en_out pulse at Q4 with file_addr_out = 7'h0C; w_wr_en_out stays 0.
- ALU_DECFSZ with alu_skip_in = 1 at Q3: next cycle has flush_out = 1, alu_op_out = ALU_NOP and no writes; pc_out advances by 2 over the two cycles.
- dec_branch_in = 1, target 13'h0123, while pc_out = 13'h0040: pc_out = 13'h0123 after Q4; the following cycle is a flush.
- pc_out = 13'h1FFF with a valid fetch: pc_out wraps to 0. With instr_valid_in = 0 at Q4: pc_out holds, instr_reg_out = 0, flush_out = 0.
- ICEPIC_EXEC_STALL_EN defined, stall_in high for 5 clocks during Q2: phase_out frozen at 1; file_rd_en_out pulses exactly once after release.

Source files
------------

// File: rtl/pic_alu_pkg.sv
// Shared ALU opcode encoding used by the iCEPIC decoder, sequencer and ALU.
package pic_alu_pkg;
   typedef enum logic [3:0] {
      ALU_NOP       = 4'd0,
      ALU_ADD       = 4'd1,
      ALU_SUB       = 4'd2,
      ALU_AND       = 4'd3,
      ALU_IOR       = 4'd4,
      ALU_XOR       = 4'd5,
      ALU_MOV       = 4'd6,
      ALU_COM       = 4'd7,
      ALU_INC       = 4'd8,
      ALU_DEC       = 4'd9,
      ALU_INCFSZ    = 4'd10,
      ALU_DECFSZ    = 4'd11,
      ALU_BIT_BCF   = 4'd12,
      ALU_BIT_BSF   = 4'd13,
      ALU_BIT_BTFSS = 4'd14,
      ALU_BIT_BTFSC = 4'd15
   } alu_op_t;
endpackage

// File: rtl/pic_exec_seq.sv
// Q1..Q4 instruction-cycle sequencer: owns PC, IR and prefetch; a skip or branch costs one flush NOP cycle.
// Optional ICEPIC_EXEC_STALL_EN adds stall_in, which freezes the phase and masks all strobes.
module pic_exec_seq
   import pic_alu_pkg::*;
#(
   parameter int          PC_W         = 13,
   parameter int          RESET_VECTOR = 0,
   parameter logic [13:0] NOP_WORD     = 14'h0000
) (
   input  logic            clk_in,
   input  logic            rst_n_in,
`ifdef ICEPIC_EXEC_STALL_EN
   input  logic            stall_in,
`endif
   input  logic [13:0]     instr_in,
   input  logic            instr_valid_in,
   input  alu_op_t         dec_alu_op_in,
   input  logic            dec_dest_f_in,
   input  logic [6:0]      dec_file_addr_in,
   input  logic            dec_branch_in,
   input  logic [PC_W-1:0] dec_target_in,
   input  logic            alu_skip_in,
   input  logic            alu_status_update_in,
   output logic [1:0]      phase_out,
   output logic [13:0]     instr_reg_out,
   output alu_op_t         alu_op_out,
   output logic            file_rd_en_out,
   output logic [6:0]      file_addr_out,
   output logic            file_wr_en_out,
   output logic            w_wr_en_out,
   output logic            status_wr_en_out,
   output logic [PC_W-1:0] pc_out,
   output logic            flush_out
);

   typedef enum logic [1:0] {PH_Q1 = 2'd0, PH_Q2 = 2'd1, PH_Q3 = 2'd2, PH_Q4 = 2'd3} phase_t;

   localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_VECTOR);
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   phase_t          phase_q, phase_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [13:0]     ir_q, ir_d;
   logic            flush_q, flush_d;
   logic            skip_q, skip_d;
   logic [6:0]      addr_q, addr_d;
   logic            adv;
   logic            active;
   logic            wb_ok;

`ifdef ICEPIC_EXEC_STALL_EN
   assign adv = ~stall_in;
`else
   assign adv = 1'b1;
`endif

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         phase_q <= PH_Q1;
         pc_q    <= PC_RST;
         ir_q    <= NOP_WORD;
         flush_q <= 1'b1;
         skip_q  <= 1'b0;
         addr_q  <= 7'd0;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         flush_q <= flush_d;
         skip_q  <= skip_d;
         addr_q  <= addr_d;
      end
   end

   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      flush_d = flush_q;
      skip_d  = skip_q;
      addr_d  = addr_q;
      if (adv) begin
         case (phase_q)
            PH_Q1: begin
               phase_d = PH_Q2;
               if (!flush_q) addr_d = dec_file_addr_in;
            end
            PH_Q2: phase_d = PH_Q3;
            PH_Q3: begin
               phase_d = PH_Q4;
               skip_d  = alu_skip_in & ~flush_q;
            end
            default: begin
               phase_d = PH_Q1;
               // Branch outranks skip; a flush cycle never starts another flush.
               if (!flush_q && dec_branch_in) begin
                  pc_d    = dec_target_in;
                  ir_d    = NOP_WORD;
                  flush_d = 1'b1;
               end else if (!flush_q && skip_q) begin
                  if (instr_valid_in) pc_d = pc_q + PC_ONE;
                  ir_d    = NOP_WORD;
                  flush_d = 1'b1;
               end else if (instr_valid_in) begin
                  pc_d    = pc_q + PC_ONE;
                  ir_d    = instr_in;
                  flush_d = 1'b0;
               end else begin
                  ir_d    = NOP_WORD;
                  flush_d = 1'b0;
               end
            end
         endcase
      end
   end

   always_comb begin
      active = adv & ~flush_q;
      wb_ok  = (dec_alu_op_in != ALU_NOP) && (dec_alu_op_in != ALU_BIT_BTFSS) &&
               (dec_alu_op_in != ALU_BIT_BTFSC);
      alu_op_out = ALU_NOP;
      if (!flush_q && (phase_q == PH_Q3 || phase_q == PH_Q4)) alu_op_out = dec_alu_op_in;
      file_rd_en_out   = active && (phase_q == PH_Q2);
      file_wr_en_out   = active && (phase_q == PH_Q4) && wb_ok && dec_dest_f_in;
      w_wr_en_out      = active && (phase_q == PH_Q4) && wb_ok && !dec_dest_f_in;
      status_wr_en_out = active && (phase_q == PH_Q4) && alu_status_update_in;
   end

   assign phase_out     = phase_q;
   assign instr_reg_out = ir_q;
   assign file_addr_out = addr_q;
   assign pc_out        = pc_q;
   assign flush_out     = flush_q;

endmodule
